// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a valid/ready input, a one-word holding
// buffer and back-to-back frame chaining.
module uart_tx_param #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 done
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_param: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DATA_BITS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_n;
  logic [DIV_W-1:0]     div_cnt, div_cnt_n;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_acc, par_acc_n;
  logic                 buf_full, buf_full_n;
  logic [DATA_BITS-1:0] buf_data, buf_data_n;

  logic bit_end;
  logic last_stop;
  logic load;
  logic accept;

  assign bit_end   = (div_cnt == DIV_LAST);
  assign last_stop = (state == S_STOP) && bit_end && (bit_cnt == STOP_LAST);
  assign accept    = tx_valid && !buf_full;

  // State, counters, shifter and holding buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_acc  <= 1'b0;
      buf_full <= 1'b0;
      buf_data <= '0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      par_acc  <= par_acc_n;
      buf_full <= buf_full_n;
      buf_data <= buf_data_n;
    end
  end

  // Next-state logic; parity accumulates from the shifter as bits go out.
  always_comb begin
    state_n    = state;
    div_cnt_n  = div_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    par_acc_n  = par_acc;
    buf_full_n = buf_full;
    buf_data_n = buf_data;
    load       = 1'b0;

    if (state != S_IDLE) begin
      div_cnt_n = bit_end ? '0 : div_cnt + 1'b1;
    end

    unique case (state)
      S_IDLE: begin
        div_cnt_n = '0;
        bit_cnt_n = '0;
        load      = buf_full;
      end
      S_START: begin
        if (bit_end) begin
          state_n   = S_DATA;
          bit_cnt_n = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          par_acc_n = par_acc ^ shift[0];
          shift_n   = {1'b0, shift[DATA_BITS-1:1]};
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_n = '0;
            state_n   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n   = S_STOP;
          bit_cnt_n = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_n = '0;
            state_n   = S_IDLE;
            load      = buf_full;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // A pending word enters the shifter from IDLE or straight out of the last
    // stop bit, so chained frames leave no idle cycle between them.
    if (load) begin
      state_n    = S_START;
      div_cnt_n  = '0;
      bit_cnt_n  = '0;
      shift_n    = buf_data;
      par_acc_n  = (PARITY == 1);
      buf_full_n = 1'b0;
    end else if (accept) begin
      buf_full_n = 1'b1;
      buf_data_n = tx_data;
    end
  end

  // Serial line level for the current state.
  always_comb begin
    tx_out = 1'b1;
    unique case (state)
      S_START:  tx_out = 1'b0;
      S_DATA:   tx_out = shift[0];
      S_PARITY: tx_out = par_acc;
      default:  tx_out = 1'b1;
    endcase
  end

  assign tx_ready = !buf_full;
  assign busy     = (state != S_IDLE);
  assign done     = last_stop;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five configurations on one clock/reset, checked
// cycle by cycle against a frame-level line model.
module tb_uart_tx_param;

  localparam int NI = 5;
  localparam int CFG_DIV [NI] = '{16, 16, 16, 4, 3};
  localparam int CFG_DB  [NI] = '{8, 8, 8, 7, 9};
  localparam int CFG_PAR [NI] = '{0, 2, 1, 0, 1};
  localparam int CFG_STP [NI] = '{1, 1, 1, 2, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] tdata  [NI];
  logic       tvalid [NI];
  logic       tready [NI];
  logic       tout   [NI];
  logic       tbusy  [NI];
  logic       tdone  [NI];

  int checks = 0;
  int errors = 0;

  // Expected line level and done flag for every future cycle.
  logic       lineq [$];
  logic       doneq [$];
  logic       mbuf;
  logic [8:0] mword;
  logic [8:0] stim_q [$];
  logic [15:0] obs_vec;
  int          last_len;

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_DIV(CFG_DIV[0]), .DATA_BITS(CFG_DB[0]), .PARITY(CFG_PAR[0]), .STOP_BITS(CFG_STP[0])) u0 (
    .clk(clk), .rst(rst), .tx_data(tdata[0][7:0]), .tx_valid(tvalid[0]), .tx_ready(tready[0]),
    .tx_out(tout[0]), .busy(tbusy[0]), .done(tdone[0]));
  uart_tx_param #(.CLK_DIV(CFG_DIV[1]), .DATA_BITS(CFG_DB[1]), .PARITY(CFG_PAR[1]), .STOP_BITS(CFG_STP[1])) u1 (
    .clk(clk), .rst(rst), .tx_data(tdata[1][7:0]), .tx_valid(tvalid[1]), .tx_ready(tready[1]),
    .tx_out(tout[1]), .busy(tbusy[1]), .done(tdone[1]));
  uart_tx_param #(.CLK_DIV(CFG_DIV[2]), .DATA_BITS(CFG_DB[2]), .PARITY(CFG_PAR[2]), .STOP_BITS(CFG_STP[2])) u2 (
    .clk(clk), .rst(rst), .tx_data(tdata[2][7:0]), .tx_valid(tvalid[2]), .tx_ready(tready[2]),
    .tx_out(tout[2]), .busy(tbusy[2]), .done(tdone[2]));
  uart_tx_param #(.CLK_DIV(CFG_DIV[3]), .DATA_BITS(CFG_DB[3]), .PARITY(CFG_PAR[3]), .STOP_BITS(CFG_STP[3])) u3 (
    .clk(clk), .rst(rst), .tx_data(tdata[3][6:0]), .tx_valid(tvalid[3]), .tx_ready(tready[3]),
    .tx_out(tout[3]), .busy(tbusy[3]), .done(tdone[3]));
  uart_tx_param #(.CLK_DIV(CFG_DIV[4]), .DATA_BITS(CFG_DB[4]), .PARITY(CFG_PAR[4]), .STOP_BITS(CFG_STP[4])) u4 (
    .clk(clk), .rst(rst), .tx_data(tdata[4]), .tx_valid(tvalid[4]), .tx_ready(tready[4]),
    .tx_out(tout[4]), .busy(tbusy[4]), .done(tdone[4]));

  // Append one whole frame for word w to the expected line.
  task automatic push_frame(input int idx, input logic [8:0] w);
    int   db, nbits, ones;
    logic par, b;
    db   = CFG_DB[idx];
    ones = 0;
    for (int i = 0; i < db; i++) ones += int'(w[i]);
    par   = ((ones % 2) == 1) ^ (CFG_PAR[idx] == 1);
    nbits = 1 + db + ((CFG_PAR[idx] != 0) ? 1 : 0) + CFG_STP[idx];
    for (int k = 0; k < nbits; k++) begin
      if (k == 0) b = 1'b0;
      else if (k <= db) b = w[k-1];
      else if (CFG_PAR[idx] != 0 && k == db + 1) b = par;
      else b = 1'b1;
      for (int c = 0; c < CFG_DIV[idx]; c++) begin
        lineq.push_back(b);
        doneq.push_back((k == nbits - 1) && (c == CFG_DIV[idx] - 1));
      end
    end
  endtask

  // mode 0: one word at a time with the line idle; mode 1: valid held with
  // words from stim_q; mode 2: valid held with tx_data changing every cycle.
  task automatic run_stream(input int idx, input int mode, input int nwords, input int budget);
    int   accepted, cyc, fcyc;
    bit   finished;
    logic eo, eb, ed, er, acc, xfer;
    accepted = 0; cyc = 0; fcyc = 0; finished = 0;
    lineq.delete(); doneq.delete();
    mbuf = 1'b0; mword = '0; obs_vec = '0; last_len = 0;
    while (!finished && cyc < budget) begin
      @(negedge clk);
      eo = (lineq.size() > 0) ? lineq[0] : 1'b1;
      eb = (lineq.size() > 0);
      ed = (doneq.size() > 0) ? doneq[0] : 1'b0;
      er = !mbuf;
      checks += 4;
      if (tout[idx] !== eo) begin
        errors++;
        $display("FAIL stream_tx_out inst %0d cycle %0d got %b want %b", idx, cyc, tout[idx], eo);
      end
      if (tbusy[idx] !== eb) begin
        errors++;
        $display("FAIL stream_busy inst %0d cycle %0d got %b want %b", idx, cyc, tbusy[idx], eb);
      end
      if (tdone[idx] !== ed) begin
        errors++;
        $display("FAIL stream_done inst %0d cycle %0d got %b want %b", idx, cyc, tdone[idx], ed);
      end
      if (tready[idx] !== er) begin
        errors++;
        $display("FAIL stream_tx_ready inst %0d cycle %0d got %b want %b", idx, cyc, tready[idx], er);
      end
      if (tbusy[idx] === 1'b1) begin
        if ((fcyc % CFG_DIV[idx]) == CFG_DIV[idx] / 2 && (fcyc / CFG_DIV[idx]) < 16)
          obs_vec[fcyc / CFG_DIV[idx]] = tout[idx];
        fcyc++;
        if (tdone[idx] === 1'b1) begin
          last_len = fcyc;
          fcyc     = 0;
        end
      end
      if (accepted == nwords && lineq.size() == 0 && !mbuf) begin
        finished    = 1;
        tvalid[idx] = 1'b0;
      end else begin
        case (mode)
          0: begin
            tvalid[idx] = (accepted < nwords) && (lineq.size() == 0) && !mbuf;
            if (stim_q.size() > 0) tdata[idx] = stim_q[0];
          end
          1: begin
            tvalid[idx] = (accepted < nwords);
            if (stim_q.size() > 0) tdata[idx] = stim_q[0];
          end
          default: begin
            tvalid[idx] = (accepted < nwords);
            tdata[idx]  = 9'($urandom);
          end
        endcase
        acc  = tvalid[idx] && !mbuf;
        xfer = mbuf && (lineq.size() <= 1);
        if (lineq.size() > 0) begin
          void'(lineq.pop_front());
          void'(doneq.pop_front());
        end
        if (xfer) begin
          push_frame(idx, mword);
          mbuf = 1'b0;
        end
        if (acc) begin
          mbuf  = 1'b1;
          mword = tdata[idx];
          accepted++;
          if (mode != 2 && stim_q.size() > 0) void'(stim_q.pop_front());
        end
      end
      cyc++;
    end
    tvalid[idx] = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL stream_timeout inst %0d accepted %0d want %0d words within %0d cycles", idx, accepted, nwords, budget);
    end
  endtask

  task automatic check_idle(input string name, input int idx);
    checks += 4;
    if (tout[idx] !== 1'b1) begin errors++; $display("FAIL %s_tx_out inst %0d got %b want 1", name, idx, tout[idx]); end
    if (tbusy[idx] !== 1'b0) begin errors++; $display("FAIL %s_busy inst %0d got %b want 0", name, idx, tbusy[idx]); end
    if (tdone[idx] !== 1'b0) begin errors++; $display("FAIL %s_done inst %0d got %b want 0", name, idx, tdone[idx]); end
    if (tready[idx] !== 1'b1) begin errors++; $display("FAIL %s_tx_ready inst %0d got %b want 1", name, idx, tready[idx]); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) check_idle("reset_held", i);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) check_idle("reset_released", i);
    // Start an all-zero frame, then pull reset mid-frame between clock edges.
    tdata[0] = 9'h000; tvalid[0] = 1'b1;
    @(negedge clk);
    tvalid[0] = 1'b0;
    repeat (50) @(negedge clk);
    checks += 2;
    if (tout[0] !== 1'b0) begin errors++; $display("FAIL midframe_pre_tx_out got %b want 0", tout[0]); end
    if (tbusy[0] !== 1'b1) begin errors++; $display("FAIL midframe_pre_busy got %b want 1", tbusy[0]); end
    #2 rst = 1'b0;
    #1 check_idle("midframe_reset", 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check_idle("after_abort", 0);
  endtask

  task automatic test_8n1();
    stim_q = '{9'h0CD};
    run_stream(0, 0, 1, 400);
    checks += 2;
    if (obs_vec[9:0] !== 10'b1_11001101_0) begin errors++; $display("FAIL 8n1_bits got %b want %b", obs_vec[9:0], 10'b1_11001101_0); end
    if (last_len !== 160) begin errors++; $display("FAIL 8n1_frame_len got %0d want 160", last_len); end
  endtask

  task automatic test_back_to_back();
    stim_q = '{9'h0CD, 9'h0A9};
    run_stream(0, 1, 2, 600);
    checks += 2;
    if (obs_vec[9:0] !== 10'b1_10101001_0) begin errors++; $display("FAIL b2b_second_bits got %b want %b", obs_vec[9:0], 10'b1_10101001_0); end
    if (last_len !== 160) begin errors++; $display("FAIL b2b_frame_len got %0d want 160", last_len); end
  endtask

  task automatic test_parity();
    stim_q = '{9'h0CD};
    run_stream(1, 0, 1, 400);
    checks += 2;
    if (obs_vec[10:0] !== 11'b1_1_11001101_0) begin errors++; $display("FAIL parity_even_cd got %b want %b", obs_vec[10:0], 11'b1_1_11001101_0); end
    if (last_len !== 176) begin errors++; $display("FAIL parity_frame_len got %0d want 176", last_len); end
    stim_q = '{9'h0CD};
    run_stream(2, 0, 1, 400);
    checks++;
    if (obs_vec[10:0] !== 11'b1_0_11001101_0) begin errors++; $display("FAIL parity_odd_cd got %b want %b", obs_vec[10:0], 11'b1_0_11001101_0); end
    stim_q = '{9'h0A9};
    run_stream(2, 0, 1, 400);
    checks++;
    if (obs_vec[10:0] !== 11'b1_1_10101001_0) begin errors++; $display("FAIL parity_odd_a9 got %b want %b", obs_vec[10:0], 11'b1_1_10101001_0); end
  endtask

  task automatic test_general();
    stim_q = '{9'h055};
    run_stream(3, 0, 1, 200);
    checks += 2;
    if (obs_vec[9:0] !== 10'b11_1010101_0) begin errors++; $display("FAIL general_bits got %b want %b", obs_vec[9:0], 10'b11_1010101_0); end
    if (last_len !== 40) begin errors++; $display("FAIL general_frame_len got %0d want 40", last_len); end
  endtask

  task automatic test_handshake();
    run_stream(0, 2, 4, 1000);
    checks++;
    if (last_len !== 160) begin errors++; $display("FAIL handshake_frame_len got %0d want 160", last_len); end
  endtask

  task automatic test_random();
    run_stream(4, 2, 8, 8 * 39 + 100);
    stim_q.delete();
    for (int i = 0; i < 6; i++) stim_q.push_back(9'($urandom));
    run_stream(3, 1, 6, 400);
    stim_q.delete();
    for (int i = 0; i < 3; i++) stim_q.push_back(9'($urandom));
    run_stream(1, 1, 3, 700);
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      tdata[i]  = '0;
      tvalid[i] = 1'b0;
    end
    test_reset();
    test_8n1();
    test_back_to_back();
    test_parity();
    test_general();
    test_handshake();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
